// File: rtl/top_mac_requant.sv
// rtl/top_mac_requant.sv - product accumulator with shift/saturate requantisation to a result stream
// Optional build macro: TOP_MAC_ROUND_EN (round-half-up before the right shift).
module top_mac_requant #(
    parameter int PROD_WIDTH = 60,
    parameter int ACC_WIDTH  = 64,
    parameter int OUT_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  cfg_len,
    input  logic [5:0]            cfg_shift,
    output logic                  busy,
    input  logic [PROD_WIDTH-1:0] prod_tdata,
    input  logic                  prod_tvalid,
    output logic                  prod_tready,
    output logic [OUT_WIDTH-1:0]  res_tdata,
    output logic                  res_tvalid,
    input  logic                  res_tready,
    output logic                  res_sat
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

    state_t                 state, state_n;
    logic [ACC_WIDTH-1:0]   acc;
    logic                   acc_sat;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [5:0]             shift;
    logic                   beat;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   acc_r;
    logic [ACC_WIDTH-1:0]   s;
    logic                   over;

    assign beat = prod_tvalid && (state == S_ACC);
    assign sum  = {1'b0, acc} + {1'b0, ACC_WIDTH'(prod_tdata)};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = (cfg_len == '0) ? S_OUT : S_ACC;
            S_ACC:  if (beat && cnt == CNT_WIDTH'(1)) state_n = S_OUT;
            S_OUT:  if (res_tready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Accumulator saturates on carry-out and remembers it until the next job.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            cnt     <= '0;
            shift   <= '0;
        end else if (state == S_IDLE && start) begin
            acc     <= '0;
            acc_sat <= 1'b0;
            cnt     <= cfg_len;
            shift   <= cfg_shift;
        end else if (beat) begin
            cnt <= cnt - CNT_WIDTH'(1);
            if (sum[ACC_WIDTH]) begin
                acc     <= '1;
                acc_sat <= 1'b1;
            end else begin
                acc <= sum[ACC_WIDTH-1:0];
            end
        end
    end

`ifdef TOP_MAC_ROUND_EN
    logic [ACC_WIDTH:0] half;
    logic [ACC_WIDTH:0] rsum;
    always_comb begin
        half = '0;
        if (shift != 6'd0) half = (ACC_WIDTH+1)'(1) << (shift - 6'd1);
        rsum  = {1'b0, acc} + half;
        acc_r = rsum[ACC_WIDTH] ? '1 : rsum[ACC_WIDTH-1:0];
    end
`else
    assign acc_r = acc;
`endif

    assign s    = acc_r >> shift;
    assign over = |s[ACC_WIDTH-1:OUT_WIDTH];

    assign busy        = (state != S_IDLE);
    assign prod_tready = (state == S_ACC);
    assign res_tvalid  = (state == S_OUT);
    assign res_tdata   = (state != S_OUT) ? '0 : (over ? '1 : s[OUT_WIDTH-1:0]);
    assign res_sat     = (state == S_OUT) && (over || acc_sat);

endmodule

// File: tb/tb_top_mac_requant.sv
// tb/tb_top_mac_requant.sv - directed table-driven bench for top_mac_requant
module tb_top_mac_requant;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        start;
    logic [15:0] cfg_len;
    logic [5:0]  cfg_shift;
    logic        busy;
    logic [59:0] prod_tdata;
    logic        prod_tvalid;
    logic        prod_tready;
    logic [31:0] res_tdata;
    logic        res_tvalid;
    logic        res_tready;
    logic        res_sat;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          len;
        int          shift;
        logic [59:0] p[4];
        bit          gap;
        logic [31:0] exp_d;
        bit          exp_s;
    } vec_t;

    vec_t vecs[$];

    top_mac_requant dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_shift   (cfg_shift),
        .busy        (busy),
        .prod_tdata  (prod_tdata),
        .prod_tvalid (prod_tvalid),
        .prod_tready (prod_tready),
        .res_tdata   (res_tdata),
        .res_tvalid  (res_tvalid),
        .res_tready  (res_tready),
        .res_sat     (res_sat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic add_vec(input int len, input int sh, input logic [59:0] p0, input logic [59:0] p1,
                           input logic [59:0] p2, input logic [59:0] p3, input bit gap,
                           input logic [31:0] d, input bit s);
        vec_t v;
        v.len = len; v.shift = sh; v.gap = gap; v.exp_d = d; v.exp_s = s;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        start = 1'b1; cfg_len = 16'(v.len); cfg_shift = 6'(v.shift);
        tick();
        start = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            if (v.gap && i == v.len - 1) begin
                prod_tvalid = 1'b0;
                tick();
                check($sformatf("v%0d gap tready", idx), prod_tready, 1'b1);
                check($sformatf("v%0d gap tvalid", idx), res_tvalid, 1'b0);
            end
            prod_tvalid = 1'b1; prod_tdata = v.p[i];
            tick();
        end
        prod_tvalid = 1'b0;
        check($sformatf("v%0d res_tvalid", idx), res_tvalid, 1'b1);
        check($sformatf("v%0d res_tdata", idx), res_tdata, v.exp_d);
        check($sformatf("v%0d res_sat", idx), res_sat, v.exp_s);
        check($sformatf("v%0d prod_tready", idx), prod_tready, 1'b0);
        res_tready = 1'b1;
        tick();
        res_tready = 1'b0;
        check($sformatf("v%0d idle tvalid", idx), res_tvalid, 1'b0);
        check($sformatf("v%0d idle busy", idx), busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ap_rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_shift = '0;
        prod_tdata = '0; prod_tvalid = 1'b0; res_tready = 1'b0;
        tick(); tick();
        check("rst busy", busy, 1'b0);
        check("rst prod_tready", prod_tready, 1'b0);
        check("rst res_tvalid", res_tvalid, 1'b0);
        check("rst res_sat", res_sat, 1'b0);
        check("rst res_tdata", res_tdata, 32'h0);
        ap_rst = 1'b0;
        tick();

        add_vec(3, 0, 60'd5, 60'd7, 60'd11, 60'd0, 1'b0, 32'd23, 1'b0);
`ifdef TOP_MAC_ROUND_EN
        add_vec(1, 4, 60'd24, 60'd0, 60'd0, 60'd0, 1'b0, 32'd2, 1'b0);
`else
        add_vec(1, 4, 60'd24, 60'd0, 60'd0, 60'd0, 1'b0, 32'd1, 1'b0);
`endif
        add_vec(1, 0, 60'h100_0000_0000, 60'd0, 60'd0, 60'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        add_vec(1, 9, 60'h100_0000_0000, 60'd0, 60'd0, 60'd0, 1'b0, 32'h8000_0000, 1'b0);
`ifdef TOP_MAC_ROUND_EN
        add_vec(2, 1, 60'd3, 60'd4, 60'd0, 60'd0, 1'b1, 32'd4, 1'b0);
`else
        add_vec(2, 1, 60'd3, 60'd4, 60'd0, 60'd0, 1'b1, 32'd3, 1'b0);
`endif
        add_vec(1, 32, 60'h800_0000_0000_0000, 60'd0, 60'd0, 60'd0, 1'b0, 32'h0800_0000, 1'b0);
        add_vec(2, 28, 60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF, 60'd0, 60'd0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        add_vec(4, 0, 60'd1, 60'd2, 60'd3, 60'd4, 1'b1, 32'd10, 1'b0);
        add_vec(0, 0, 60'd0, 60'd0, 60'd0, 60'd0, 1'b0, 32'd0, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Accumulator overflow: 32 maximal products pin acc at all-ones.
        start = 1'b1; cfg_len = 16'd32; cfg_shift = 6'd63;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            prod_tvalid = 1'b1; prod_tdata = 60'hFFF_FFFF_FFFF_FFFF;
            tick();
        end
        prod_tvalid = 1'b0;
        check("ovf res_tvalid", res_tvalid, 1'b1);
        check("ovf res_tdata", res_tdata, 32'd1);
        check("ovf res_sat", res_sat, 1'b1);
        res_tready = 1'b1; tick(); res_tready = 1'b0;

        // Output backpressure: result held, start ignored, no product acceptance.
        start = 1'b1; cfg_len = 16'd1; cfg_shift = 6'd0;
        tick();
        start = 1'b0; prod_tvalid = 1'b1; prod_tdata = 60'd9;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; cfg_len = 16'd0; cfg_shift = 6'd3; end
            else start = 1'b0;
            tick();
            check($sformatf("bp%0d res_tvalid", i), res_tvalid, 1'b1);
            check($sformatf("bp%0d res_tdata", i), res_tdata, 32'd9);
            check($sformatf("bp%0d prod_tready", i), prod_tready, 1'b0);
        end
        start = 1'b0; prod_tvalid = 1'b0;
        res_tready = 1'b1; tick(); res_tready = 1'b0;
        check("bp after busy", busy, 1'b0);
        check("bp after tvalid", res_tvalid, 1'b0);

        // Reset in the middle of a 4-beat job discards it.
        start = 1'b1; cfg_len = 16'd4; cfg_shift = 6'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_tvalid = 1'b1; prod_tdata = 60'd100;
            tick();
        end
        prod_tvalid = 1'b0;
        check("mid busy before rst", busy, 1'b1);
        ap_rst = 1'b1;
        #2;
        check("mid rst busy", busy, 1'b0);
        check("mid rst prod_tready", prod_tready, 1'b0);
        check("mid rst res_tvalid", res_tvalid, 1'b0);
        tick();
        ap_rst = 1'b0;
        tick();
        check("post rst res_tvalid", res_tvalid, 1'b0);
        begin
            vec_t v;
            v.len = 2; v.shift = 0; v.gap = 1'b0; v.exp_d = 32'd3; v.exp_s = 1'b0;
            v.p[0] = 60'd1; v.p[1] = 60'd2; v.p[2] = 60'd0; v.p[3] = 60'd0;
            run_vec(v, 99);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
